// File: rtl/video_timing_checker.sv
// rtl/video_timing_checker.sv - 480p sink-side timing monitor with lock detection and dot-hit counting
//
// Measures line/frame geometry of an incoming rgb/hsync/vsync/de stream, locks
// after LOCK_FRAMES consecutive matching frames, keeps sticky error flags and
// counts HIT_COLOR pixels per frame.
//
// Ports:
//   clk_pixel      pixel clock
//   rst_n          asynchronous active-low reset
//   rgb_pixel      24-bit pixel, R[23:16] G[15:8] B[7:0]
//   hsync, vsync   active-high sync regions
//   de             active video
//   clr_err        one-cycle pulse clearing err_flags (a simultaneous set wins)
//   locked         stream matches expected timing
//   frame_done     one-cycle pulse when per-frame results update
//   meas_h_total   clocks in last complete line
//   meas_h_active  DE count of last line that had DE
//   meas_v_total   hsync rises in last frame
//   meas_v_active  lines with DE in last frame
//   hit_count      HIT_COLOR DE pixels in last frame, saturating
//   err_flags      sticky: [0] h_total, [1] h_active, [2] v_total, [3] v_active
module video_timing_checker #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_TOTAL     = 800,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_TOTAL     = 525,
    parameter int          LOCK_FRAMES = 2,
    parameter logic [23:0] HIT_COLOR   = 24'hFFFFFF
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [23:0] rgb_pixel,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic        clr_err,
    output logic        locked,
    output logic        frame_done,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_active,
    output logic [10:0] meas_v_total,
    output logic [10:0] meas_v_active,
    output logic [15:0] hit_count,
    output logic [3:0]  err_flags
);

    localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
    localparam logic [11:0] H_ACTIVE_W = 12'(H_ACTIVE);
    localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
    localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);
    localparam logic [11:0] WD_LIMIT   = 12'(2 * H_TOTAL);
    localparam logic [3:0]  LOCK_W     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state, state_n;
    logic [3:0]  match_cnt, match_n;
    logic        locked_n, fdone_n;
    logic [3:0]  err_set;

    logic        hs_r, hs_rr, vs_r, vs_rr, de_r;
    logic [23:0] rgb_r;
    logic [11:0] lclk, lde;
    logic [10:0] lines, vact;
    logic [15:0] hits;
    logic        mm_ht, mm_ha;
    logic        first_line;

    logic        hs_rise, vs_rise, ht_bad, ha_bad, frame_ok, watchdog;
    logic [3:0]  frame_err;

    assign hs_rise = hs_r & ~hs_rr;
    assign vs_rise = vs_r & ~vs_rr;

    // The first line after leaving SEARCH may be partial, so its length is not judged.
    assign ht_bad = hs_rise && !first_line && (lclk != H_TOTAL_W);
    assign ha_bad = hs_rise && (lde != 12'd0) && (lde != H_ACTIVE_W);

    assign frame_err = {vact != V_ACTIVE_W, lines != V_TOTAL_W, mm_ha, mm_ht};
    assign frame_ok  = (frame_err == 4'b0000);
    assign watchdog  = (state != SEARCH) && (lclk == WD_LIMIT);

    always_comb begin
        state_n  = state;
        match_n  = match_cnt;
        locked_n = locked;
        err_set  = 4'b0000;
        fdone_n  = 1'b0;
        if (watchdog) begin
            state_n    = SEARCH;
            locked_n   = 1'b0;
            err_set[0] = 1'b1;
        end else if (vs_rise) begin
            case (state)
                SEARCH: begin
                    state_n = VERIFY;
                    match_n = 4'd0;
                end
                VERIFY: begin
                    fdone_n = 1'b1;
                    if (frame_ok) begin
                        match_n = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == LOCK_W) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        err_set = frame_err;
                        state_n = SEARCH;
                    end
                end
                LOCKED: begin
                    fdone_n = 1'b1;
                    if (!frame_ok) begin
                        err_set  = frame_err;
                        state_n  = SEARCH;
                        locked_n = 1'b0;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEARCH;
            match_cnt     <= 4'd0;
            locked        <= 1'b0;
            frame_done    <= 1'b0;
            err_flags     <= 4'b0000;
            meas_h_total  <= 12'd0;
            meas_h_active <= 12'd0;
            meas_v_total  <= 11'd0;
            meas_v_active <= 11'd0;
            hit_count     <= 16'd0;
            hs_r          <= 1'b0;
            hs_rr         <= 1'b0;
            vs_r          <= 1'b0;
            vs_rr         <= 1'b0;
            de_r          <= 1'b0;
            rgb_r         <= 24'd0;
            lclk          <= 12'd0;
            lde           <= 12'd0;
            lines         <= 11'd0;
            vact          <= 11'd0;
            hits          <= 16'd0;
            mm_ht         <= 1'b0;
            mm_ha         <= 1'b0;
            first_line    <= 1'b1;
        end else begin
            state      <= state_n;
            match_cnt  <= match_n;
            locked     <= locked_n;
            frame_done <= fdone_n;
            err_flags  <= (err_flags & ~{4{clr_err}}) | err_set;

            hs_r  <= hsync;
            hs_rr <= hs_r;
            vs_r  <= vsync;
            vs_rr <= vs_r;
            de_r  <= de;
            rgb_r <= rgb_pixel;

            if (hs_rise)
                lclk <= 12'd1;
            else if (lclk != 12'hFFF)
                lclk <= lclk + 12'd1;

            if (hs_rise)
                lde <= 12'd0;
            else if (de_r && lde != 12'hFFF)
                lde <= lde + 12'd1;

            if (hs_rise) begin
                meas_h_total <= lclk;
                if (lde != 12'd0)
                    meas_h_active <= lde;
            end

            if (state == SEARCH)
                first_line <= 1'b1;
            else if (hs_rise)
                first_line <= 1'b0;

            // Results are latched only when a frame is actually evaluated.
            if (fdone_n) begin
                meas_v_total  <= lines;
                meas_v_active <= vact;
                hit_count     <= hits;
            end

            if (vs_rise) begin
                lines <= 11'd0;
                vact  <= 11'd0;
                hits  <= 16'd0;
                mm_ht <= 1'b0;
                mm_ha <= 1'b0;
            end else begin
                if (hs_rise && lines != 11'h7FF)
                    lines <= lines + 11'd1;
                if (hs_rise && lde != 12'd0 && vact != 11'h7FF)
                    vact <= vact + 11'd1;
                if (de_r && rgb_r == HIT_COLOR && hits != 16'hFFFF)
                    hits <= hits + 16'd1;
                if (ht_bad)
                    mm_ht <= 1'b1;
                if (ha_bad)
                    mm_ha <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_checker.sv
// tb/tb_video_timing_checker.sv - directed self-checking bench for video_timing_checker
module tb_video_timing_checker;

    localparam int          H_ACT = 8;
    localparam int          H_TOT = 12;
    localparam int          V_ACT = 6;
    localparam int          V_TOT = 9;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [23:0] rgb_pixel;
    logic        hsync, vsync, de, clr_err;
    logic        locked, frame_done;
    logic [11:0] meas_h_total, meas_h_active;
    logic [10:0] meas_v_total, meas_v_active;
    logic [15:0] hit_count;
    logic [3:0]  err_flags;

    video_timing_checker #(
        .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
        .LOCK_FRAMES(2), .HIT_COLOR(WHITE)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .rgb_pixel(rgb_pixel),
        .hsync(hsync), .vsync(vsync), .de(de), .clr_err(clr_err),
        .locked(locked), .frame_done(frame_done),
        .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
        .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
        .hit_count(hit_count), .err_flags(err_flags)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_vec = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int fd0;

    int stretch_y = -1;
    int skip_de_y = -1;
    int hit_mode  = 0;
    int clr_y     = -1;
    int clr_x     = -1;
    logic fd_at0, fd_at1, lk_at0, lk_at1;

    always @(negedge clk_pixel)
        if (frame_done) fd_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_pix(input logic h, input logic v, input logic d,
                             input logic [23:0] c, input logic clr);
        hsync = h; vsync = v; de = d; rgb_pixel = c; clr_err = clr;
        @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [23:0] pix_color(input int x, input int y);
        if (hit_mode == 0) return 24'h000000;
        if (((x < 2 || (x >= 4 && x < 6)) && y < 2) ||
            ((x < 2 || x >= 6) && (y == 3 || y == 4)))
            return WHITE;
        if (x == 3 && y == 5) return 24'hFFFFFE;
        return 24'h102030;
    endfunction

    // vsync occupies line nlines-2; hsync sits at x = H_ACT+1 .. H_ACT+2.
    task automatic run_frame(input int nlines, input bit big);
        int w;
        logic d, h, v, c;
        logic [23:0] col;
        for (int y = 0; y < nlines; y++) begin
            w = (y == stretch_y) ? H_TOT + 1 : H_TOT;
            for (int x = 0; x < w; x++) begin
                d   = big ? (y < nlines - 2) : (x < H_ACT && y < V_ACT && y != skip_de_y);
                col = big ? WHITE : pix_color(x, y);
                h   = (x >= H_ACT + 1 && x <= H_ACT + 2);
                v   = (y == nlines - 2);
                c   = (y == clr_y && x == clr_x);
                drive_pix(h, v, d, col, c);
                if (v && x == 0) begin fd_at0 = frame_done; lk_at0 = locked; end
                if (v && x == 1) begin fd_at1 = frame_done; lk_at1 = locked; end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_pix(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(3);
        check("rst_meas", {meas_h_total, meas_h_active, meas_v_total, meas_v_active}, 64'd0);
        check("rst_misc", {locked, frame_done, hit_count, err_flags}, 64'd0);
        rst_n = 1'b1;

        // nominal lock
        fd0 = fd_cnt;
        run_frame(V_TOT, 0);
        check("search_no_fd", fd_cnt - fd0, 0);
        check("f1_locked", locked, 0);
        run_frame(V_TOT, 0);
        check("f2_fd_cnt", fd_cnt - fd0, 1);
        check("f2_locked", locked, 0);
        run_frame(V_TOT, 0);
        check("f3_fd_timing", {fd_at0, fd_at1}, 2'b01);
        check("f3_lock_timing", {lk_at0, lk_at1}, 2'b01);
        check("h_total", meas_h_total, H_TOT);
        check("h_active", meas_h_active, H_ACT);
        check("v_total", meas_v_total, V_TOT);
        check("v_active", meas_v_active, V_ACT);
        check("nom_err", err_flags, 0);
        check("nom_hits", hit_count, 0);

        // dots plus a near-miss pixel
        hit_mode = 1;
        run_frame(V_TOT, 0);
        hit_mode = 0;
        check("dot_hits", hit_count, 16);
        check("dot_locked", locked, 1);

        // stretched line
        stretch_y = 2;
        run_frame(V_TOT, 0);
        stretch_y = -1;
        check("stretch_fd", fd_at1, 1);
        check("stretch_locked", locked, 0);
        check("stretch_err", err_flags, 4'b0001);
        fd0 = fd_cnt;
        run_frame(V_TOT, 0);
        check("relock_search_fd", fd_cnt - fd0, 0);
        run_frame(V_TOT, 0);
        check("relock_f2", locked, 0);
        run_frame(V_TOT, 0);
        check("relock_f3", locked, 1);

        // missing DE line, clear behaviour
        clr_y = 0; clr_x = 3;
        run_frame(V_TOT, 0);
        check("clr_alone_1", err_flags, 0);
        clr_y = -1;
        skip_de_y = 5;
        run_frame(V_TOT, 0);
        skip_de_y = -1;
        check("vact_err", err_flags, 4'b1000);
        check("vact_meas", meas_v_active, V_ACT - 1);
        check("vact_unlock", locked, 0);
        run_frame(V_TOT, 0);
        skip_de_y = 5; clr_y = V_TOT - 2; clr_x = 1;
        run_frame(V_TOT, 0);
        skip_de_y = -1;
        check("set_wins", err_flags, 4'b1000);
        clr_y = 0; clr_x = 3;
        run_frame(V_TOT, 0);
        clr_y = -1;
        check("clr_alone_2", err_flags, 0);

        // hit-count and line-count saturation
        run_frame(5470, 1);
        check("hit_sat", hit_count, 16'hFFFF);
        check("vtot_sat", meas_v_total, 11'h7FF);
        check("big_err", err_flags, 4'b1110);

        clr_y = 0; clr_x = 3;
        run_frame(V_TOT, 0);
        clr_y = -1;
        run_frame(V_TOT, 0);
        run_frame(V_TOT, 0);
        check("relock_big", {locked, err_flags}, 5'b10000);

        // watchdog
        fd0 = fd_cnt;
        idle(20);
        check("wd_early", locked, 1);
        idle(20);
        check("wd_locked", locked, 0);
        check("wd_err", err_flags, 4'b0001);
        check("wd_no_fd", fd_cnt - fd0, 0);

        // asynchronous reset mid-line
        run_frame(V_TOT, 0);
        run_frame(V_TOT, 0);
        run_frame(V_TOT, 0);
        check("pre_rst_locked", locked, 1);
        for (int x = 0; x < 5; x++) drive_pix(1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_meas", {meas_h_total, meas_h_active, meas_v_total, meas_v_active}, 64'd0);
        check("arst_misc", {locked, frame_done, hit_count, err_flags}, 64'd0);
        idle(3);
        rst_n = 1'b1;
        run_frame(V_TOT, 0);
        run_frame(V_TOT, 0);
        check("post_rst_f2", locked, 0);
        run_frame(V_TOT, 0);
        check("post_rst_f3", {lk_at0, lk_at1}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_checker.md
Name: video_timing_checker

Overview:
- Sink-side monitor for the 480p video stream: consumes rgb_pixel/hsync/vsync/de exactly as the constellation video path emits them.
- Measures line/frame geometry, locks when the stream matches the expected timing, flags deviations, and counts symbol-dot pixels per frame.
- Sits on the clk_pixel domain next to the TMDS/HDMI encoder; used for on-chip self-test and as a simulation scoreboard.

Parameters:
H_ACTIVE, 640, expected active pixels per line
H_TOTAL, 800, expected clocks per line
V_ACTIVE, 480, expected lines containing DE per frame
V_TOTAL, 525, expected lines per frame
LOCK_FRAMES, 2, consecutive matching frames needed to assert locked (1..15)
HIT_COLOR, 24'hFFFFFF, pixel value counted as a dot hit

Ports:
clk_pixel  in  1  pixel clock (25.2 MHz)
rst_n  in  1  reset, asynchronous, active-low
rgb_pixel  in  24  R[23:16] G[15:8] B[7:0]
hsync  in  1  active-high during horizontal sync region
vsync  in  1  active-high during vertical sync region
de  in  1  active video
clr_err  in  1  one-cycle pulse clearing err_flags
locked  out  1  stream matches expected timing
frame_done  out  1  one-cycle pulse when per-frame results update
meas_h_total  out  12  clocks in last complete line
meas_h_active  out  12  DE count of last line with DE>0
meas_v_total  out  11  hsync rises in last frame
meas_v_active  out  11  lines with DE>0 in last frame
hit_count  out  16  DE pixels equal to HIT_COLOR in last frame, saturating
err_flags  out  4  sticky: [0] h_total, [1] h_active, [2] v_total, [3] v_active

Behaviour:
- Reset: all outputs 0; FSM = SEARCH; all counters 0. Reset mid-frame aborts the frame; relock starts from SEARCH.
- Inputs registered once (stage r), then edge-detected against stage rr. hs_rise = hs_r & ~hs_rr; vs_rise likewise. de/rgb use stage r, so they stay aligned.
- Line clock counter (12 b):
  - On hs_rise: evaluate the line, then load 1.
  - Otherwise increment, saturating at 4095.
  - Not reset by vs_rise.
- Line DE counter (12 b): counts de_r high cycles; evaluated and cleared on hs_rise.
- Line evaluation on hs_rise:
  - meas_h_total <= line counter value (clocks since previous hs_rise).
  - If DE count > 0: meas_h_active <= DE count; v_active counter +1.
  - Per-frame mismatch bits: h_total bit set if value != H_TOTAL, ignoring the first hs_rise after SEARCH. h_active bit set if DE count is nonzero and != H_ACTIVE.
- Line counter (11 b): +1 per hs_rise, saturating at 2047.
- Frame evaluation on vs_rise (frame boundary):
  - Latch meas_v_total, meas_v_active, hit_count.
  - Evaluate the frame, then clear the line/v_active/hit counters and per-frame mismatch bits.
  - frame_done pulses in the cycle the latched values first appear: 2 clk_pixel edges after vsync is first presented high.
  - Suppressed in SEARCH.
- Frame match requires all four: no h_total mismatch, no h_active mismatch, v_total == V_TOTAL, v_active == V_ACTIVE.
- Hit counter (16 b): +1 when de_r && rgb_r == HIT_COLOR; saturates at 16'hFFFF.
- FSM:
  - SEARCH: wait for vs_rise, then enter VERIFY with match_cnt = 0 (the partial frame is discarded).
  - VERIFY: on each vs_rise, a match increments match_cnt; when it reaches LOCK_FRAMES, go to LOCKED and set locked = 1. A mismatch sets err bits and returns to SEARCH.
  - LOCKED: on each vs_rise, a match stays LOCKED. A mismatch sets err bits, clears locked and returns to SEARCH.
- Watchdog: in VERIFY or LOCKED, line counter reaching 2*H_TOTAL (no hsync) forces SEARCH, clears locked, and sets err_flags[0].
- err_flags:
  - Set only from VERIFY, LOCKED or watchdog.
  - Cleared by clr_err.
  - If set and clear happen in the same cycle, set wins.
- locked and the FSM register update in the same cycle as frame_done.

Test Plan:
1. Nominal 640x480 @ 800x525 stream, 4 frames -> SEARCH exits at vs_rise #1; locked=1 with frame_done at vs_rise #3; meas_h_total=800, meas_h_active=640, meas_v_total=525, meas_v_active=480; err_flags=0.
2. Locked stream, one line stretched to 801 clocks -> at next frame_done: locked=0, err_flags=4'b0001, FSM in SEARCH; relock after 2 further good frames.
3. Locked stream with four 2x2 HIT_COLOR dots, plus one 24'hFFFFFE pixel -> hit_count=16; 4096×20 hit pixels -> hit_count=16'hFFFF.
4. hsync held low while LOCKED -> 1600 clocks after the last hs_rise: locked=0, err_flags[0]=1, no frame_done.
5. Frame with 479 DE lines -> err_flags=4'b1000, meas_v_active=479. Then clr_err pulsed on the cycle a new v_active error sets -> bit remains 1. clr_err alone -> err_flags=0.
6. rst_n asserted mid-line while LOCKED -> all outputs 0 immediately (asynchronous). After release, locked returns only at the 3rd vs_rise.
